// File: rtl/vdp_timing_pkg.sv
// -----------------------------------------------------------------------------
// vdp_timing_pkg
// Shared definitions for the VDP horizontal timing block:
//   - mode index encoding used to select an event's mode-enable bit
//   - event table entry layout {start, end, mask}
//   - default H counter jump points for H32 and H40
//   - mode_index() helper mapping the (h40, m5) shadow pair to a mode index
// -----------------------------------------------------------------------------
package vdp_timing_pkg;

  localparam int HCNT_W = 9;

  // Mode index. Also the bit position inside an event's 3-bit mask.
  typedef enum logic [1:0] {
    MODE_M4    = 2'd0,
    MODE_M5H32 = 2'd1,
    MODE_M5H40 = 2'd2
  } mode_idx_t;

  // One programmable event channel. A disabled channel has mask == 0.
  typedef struct packed {
    logic [HCNT_W-1:0] start_cnt;
    logic [HCNT_W-1:0] end_cnt;
    logic [2:0]        mask;
  } ev_entry_t;

  // Default jump points: END is the last linear count, RESUME follows it.
  localparam logic [HCNT_W-1:0] H32_END_DEF    = 9'h127;
  localparam logic [HCNT_W-1:0] H32_RESUME_DEF = 9'h1D2;
  localparam logic [HCNT_W-1:0] H40_END_DEF    = 9'h16C;
  localparam logic [HCNT_W-1:0] H40_RESUME_DEF = 9'h1C9;

  // h40 is only ever set together with m5, so Mode 4 wins when m5 is low.
  function automatic mode_idx_t mode_index(input logic h40, input logic m5);
    if (!m5)     return MODE_M4;
    else if (h40) return MODE_M5H40;
    else          return MODE_M5H32;
  endfunction

endpackage

// File: rtl/vdp_htiming_gen_if.sv
// -----------------------------------------------------------------------------
// vdp_htiming_gen_if
// Event table write port of the horizontal timing generator.
//   EV_WE     write strobe, one MCLK per write
//   EV_ADDR   channel to write (values >= N_EV are ignored by the slave)
//   EV_START  first count of the window
//   EV_END    last count of the window (inclusive)
//   EV_MASK   mode enable: bit0 M4/H32, bit1 M5/H32, bit2 M5/H40
// master: the register/CPU side driving writes; slave: the timing generator.
// -----------------------------------------------------------------------------
interface vdp_htiming_gen_if #(
  parameter int N_EV  = 8,
  parameter int CNT_W = 9
);

  localparam int ADDR_W = (N_EV > 1) ? $clog2(N_EV) : 1;

  logic              EV_WE;
  logic [ADDR_W-1:0] EV_ADDR;
  logic [CNT_W-1:0]  EV_START;
  logic [CNT_W-1:0]  EV_END;
  logic [2:0]        EV_MASK;

  modport master (
    output EV_WE,
    output EV_ADDR,
    output EV_START,
    output EV_END,
    output EV_MASK
  );

  modport slave (
    input EV_WE,
    input EV_ADDR,
    input EV_START,
    input EV_END,
    input EV_MASK
  );

endinterface

// File: rtl/vdp_hwin_cmp.sv
// -----------------------------------------------------------------------------
// vdp_hwin_cmp
// Combinational window hit for one event channel.
//   cnt        count under test
//   win_start  window first count
//   win_end    window last count (inclusive)
//   mask       per-mode enable bits, indexed by mode
//   mode       mode index of the line cnt belongs to
//   hit        cnt is inside the window and the channel is enabled in mode
// A window with start > end wraps through all-ones back to 0.
// -----------------------------------------------------------------------------
module vdp_hwin_cmp
  import vdp_timing_pkg::*;
#(
  parameter int CNT_W = HCNT_W
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] win_start,
  input  logic [CNT_W-1:0] win_end,
  input  logic [2:0]       mask,
  input  mode_idx_t        mode,
  output logic             hit
);

  logic in_win;
  logic mode_en;

  // NOTE: every always_comb output gets a value on every path (defaults or
  // full if/else and case default), otherwise synthesis infers a latch.
  always_comb begin
    if (win_start <= win_end) begin
      in_win = (cnt >= win_start) && (cnt <= win_end);
    end else begin
      in_win = (cnt >= win_start) || (cnt <= win_end);
    end

    case (mode)
      MODE_M4:    mode_en = mask[0];
      MODE_M5H32: mode_en = mask[1];
      MODE_M5H40: mode_en = mask[2];
      default:    mode_en = 1'b0;
    endcase

    hit = in_win & mode_en;
  end

endmodule

// File: rtl/vdp_htiming_gen.sv
// -----------------------------------------------------------------------------
// vdp_htiming_gen
// Horizontal timing generator: 9-bit H counter with mode-dependent jump,
// per-line mode shadow, line-start pulse and N_EV programmable window strobes.
//   MCLK        master clock
//   RESn        asynchronous active-low reset
//   DCLK_EN     count enable (pixel clock strobe)
//   H40, M5     requested mode; sampled into the shadow at each line start
//   ev_bus      event table write port (slave side)
//   HCNT        current H count
//   H40_ACT     40-cell mode shadow in use for this line
//   M5_ACT      Mode 5 shadow in use for this line
//   LINE_START  one-MCLK pulse on the step into count 0
//   EV_OUT      event strobes, registered together with HCNT
// Events are evaluated on the next count and next mode shadow so that EV_OUT
// always matches the HCNT value it is registered with. The event table width
// follows the package HCNT_W, which CNT_W is expected to equal.
// -----------------------------------------------------------------------------
module vdp_htiming_gen
  import vdp_timing_pkg::*;
#(
  parameter int               CNT_W      = HCNT_W,
  parameter int               N_EV       = 8,
  parameter logic [CNT_W-1:0] H32_END    = H32_END_DEF,
  parameter logic [CNT_W-1:0] H32_RESUME = H32_RESUME_DEF,
  parameter logic [CNT_W-1:0] H40_END    = H40_END_DEF,
  parameter logic [CNT_W-1:0] H40_RESUME = H40_RESUME_DEF
) (
  input  logic                MCLK,
  input  logic                RESn,
  input  logic                DCLK_EN,
  input  logic                H40,
  input  logic                M5,
  vdp_htiming_gen_if.slave    ev_bus,
  output logic [CNT_W-1:0]    HCNT,
  output logic                H40_ACT,
  output logic                M5_ACT,
  output logic                LINE_START,
  output logic [N_EV-1:0]     EV_OUT
);

  logic [CNT_W-1:0] end_sel;
  logic [CNT_W-1:0] resume_sel;
  logic [CNT_W-1:0] cnt_nxt;
  logic             wrap_nxt;
  logic             h40_nxt;
  logic             m5_nxt;
  mode_idx_t        mode_nxt;
  logic [N_EV-1:0]  ev_hit;

  ev_entry_t        ev_tab [N_EV];

  // ---------------------------------------------------------------------------
  // Next count and next mode shadow.
  // Only equality with END triggers the jump, so a count sitting in the gap
  // (above END, below RESUME) just runs linearly to all-ones and wraps.
  // ---------------------------------------------------------------------------
  always_comb begin
    end_sel    = H40_ACT ? H40_END    : H32_END;
    resume_sel = H40_ACT ? H40_RESUME : H32_RESUME;

    if (HCNT == end_sel) begin
      cnt_nxt = resume_sel;
    end else if (&HCNT) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = HCNT + 1'b1;
    end

    wrap_nxt = (cnt_nxt == '0);

    // The shadow changes only at the line boundary; H40 without M5 is H32.
    h40_nxt = H40_ACT;
    m5_nxt  = M5_ACT;
    if (wrap_nxt) begin
      h40_nxt = H40 & M5;
      m5_nxt  = M5;
    end

    mode_nxt = mode_index(h40_nxt, m5_nxt);
  end

  // ---------------------------------------------------------------------------
  // Window comparators, one per channel, all looking at the next count.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < N_EV; g++) begin : g_ev
    vdp_hwin_cmp #(
      .CNT_W (CNT_W)
    ) u_cmp (
      .cnt       (cnt_nxt),
      .win_start (ev_tab[g].start_cnt),
      .win_end   (ev_tab[g].end_cnt),
      .mask      (ev_tab[g].mask),
      .mode      (mode_nxt),
      .hit       (ev_hit[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Counter, mode shadow and output registers.
  // LINE_START is rewritten every MCLK so it is never wider than one MCLK,
  // even when DCLK_EN is sparse.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge MCLK or negedge RESn) begin
    if (!RESn) begin
      HCNT       <= '0;
      H40_ACT    <= 1'b0;
      M5_ACT     <= 1'b0;
      LINE_START <= 1'b0;
      EV_OUT     <= '0;
    end else begin
      LINE_START <= DCLK_EN & wrap_nxt;
      if (DCLK_EN) begin
        HCNT    <= cnt_nxt;
        H40_ACT <= h40_nxt;
        M5_ACT  <= m5_nxt;
        EV_OUT  <= ev_hit;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event table. Writes are independent of DCLK_EN; a write on the same edge
  // as an enabled step lands after that step has used the old entry.
  // ---------------------------------------------------------------------------
  // NOTE: this small register table is deliberately reset: an uncleared
  // table would fire stale windows after reset. Large RAMs are not reset.
  always_ff @(posedge MCLK or negedge RESn) begin
    if (!RESn) begin
      for (int i = 0; i < N_EV; i++) begin
        ev_tab[i] <= '0;
      end
    end else if (ev_bus.EV_WE) begin
      for (int i = 0; i < N_EV; i++) begin
        if (int'(ev_bus.EV_ADDR) == i) begin
          ev_tab[i].start_cnt <= ev_bus.EV_START;
          ev_tab[i].end_cnt   <= ev_bus.EV_END;
          ev_tab[i].mask      <= ev_bus.EV_MASK;
        end
      end
    end
  end

endmodule

// File: doc/vdp_htiming_gen.md
Name: vdp_htiming_gen

Overview:
Parametrised horizontal timing generator for the VDP. It owns the 9-bit H counter and its mode-dependent jump/wrap. It also generates N_EV programmable window strobes, replacing hard-wired per-count decode with a register-loaded event table. It sits beside the slot/FIFO sequencer and drives it, the sprite engine and the sync/blank logic. All outputs are registered.

Parameters:
CNT_W, 9, H counter width.
N_EV, 8, number of programmable event channels (>=1).
H32_END, 9'h127, last linear count in H32 before jump.
H32_RESUME, 9'h1D2, count following H32_END.
H40_END, 9'h16C, last linear count in H40 before jump.
H40_RESUME, 9'h1C9, count following H40_END.

Ports:
MCLK  in  1  master clock.
RESn  in  1  reset.
DCLK_EN  in  1  count enable (pixel clock strobe).
H40  in  1  requested 40-cell mode.
M5  in  1  requested Mode 5 (0 = Mode 4).
EV_WE  in  1  event table write strobe.
EV_ADDR  in  clog2(N_EV)  channel to write.
EV_START  in  CNT_W  window first count.
EV_END  in  CNT_W  window last count (inclusive).
EV_MASK  in  3  mode enable: bit0 M4/H32, bit1 M5/H32, bit2 M5/H40.
HCNT  out  CNT_W  current H count.
H40_ACT  out  1  mode shadow in use for this line.
M5_ACT  out  1  mode shadow in use for this line.
LINE_START  out  1  one-MCLK pulse on the step into count 0.
EV_OUT  out  N_EV  event window strobes aligned to HCNT.

Behaviour:
- Clocking: one clock, MCLK. Reset RESn is asynchronous, active-low.
- Reset values: HCNT=0, H40_ACT=0, M5_ACT=0, LINE_START=0, EV_OUT=0. Every table entry resets to START=0, END=0, MASK=0, i.e. disabled.
- Effective mode: h40e = H40 & M5, because H40 without M5 is treated as H32. mode index: M4=0, M5/H32=1, M5/H40=2.
- Counter: advances only on MCLK edges where DCLK_EN=1; otherwise every output holds, except LINE_START.
  - Next count: if HCNT==END(mode) -> RESUME(mode); else if HCNT==all-ones -> 0; else HCNT+1.
  - END and RESUME are selected by H40_ACT.
  - Line length is 342 steps in H32 and 420 in H40.
- Mode shadow: H40_ACT/M5_ACT load h40e/M5 only on the enabled step where the next count is 0. Mid-line mode changes do not affect the current line.
- Robustness: if a parameter set or mode switch places HCNT above END but below RESUME, the counter keeps incrementing linearly to all-ones and wraps. It never locks up.
- LINE_START: set on the enabled edge where the next count is 0; cleared on the following MCLK edge regardless of DCLK_EN.
- Events: EV_OUT[i] is computed from the next count and the next mode shadow, and registered on the same edge as HCNT, so EV_OUT is always consistent with the HCNT it accompanies.
  - Window test for count c: if START<=END, active when START<=c<=END. Otherwise the window wraps and is active when c>=START or c<=END.
  - Output: EV_OUT[i] = window(c) & MASK[mode index].
  - START==END gives exactly one count step.
  - A window may span the jump gap; counts in the gap never occur.
- Table writes: on the MCLK edge with EV_WE=1, independent of DCLK_EN. A write coinciding with an enabled step is not seen by that step; it is used from the next enabled step. EV_ADDR >= N_EV is ignored.
- Reset mid-line: everything returns to its reset value immediately. The table is cleared too, so software reloads it.

Decomposition:
- Shared package vdp_timing_pkg:
  - mode index encoding (MODE_M4, MODE_M5H32, MODE_M5H40).
  - event entry typedef {start, end, mask}.
  - default jump constants.
- One sub-module, vdp_hwin_cmp. It takes count, start, end, mask and mode index, and returns the combinational window hit. It is instantiated N_EV times.
- Counter, mode shadow, table registers and output registers stay in the top module.

Test Plan:
- Reset, H40=0, M5=1, DCLK_EN=1 constantly -> HCNT runs 0..0x127, 0x1D2..0x1FF, 0. LINE_START is high for 1 cycle at each 0. The period is 342 enabled steps.
- H40=1 asserted mid-line at HCNT=0x050 -> the current line still jumps 0x127->0x1D2. The next line runs 0x16C->0x1C9 with period 420 and H40_ACT=1.
- Channel 0 loaded with START=0x1E0, END=0x005, MASK=3'b111 -> EV_OUT[0] is high for HCNT 0x1E0..0x1FF and 0x000..0x005, low at 0x006. The strobe stays aligned to HCNT.
- Channel 1 loaded with START=END=0x020, MASK=3'b100, in M5/H32 -> never asserts. After switching to H40 at line start -> exactly one step at 0x020.
- DCLK_EN toggled 1-in-4 -> HCNT and EV_OUT change only on enabled edges, and LINE_START stays 1 MCLK wide. An EV_WE pulse on a disabled cycle takes effect at the next enabled step.
- H40=1, M5=0 -> H32 sequence, mask bit0 gates events. Reset asserted at HCNT=0x100 -> HCNT=0 and EV_OUT=0 asynchronously, and all events are disabled until the table is reloaded.
